// File: rtl/square_wave_detector.sv
// Purpose: measures the half-period of an asynchronous square wave and recovers the
//          generator's frequency code (toggle every code+1 clocks), with lock and loss-of-signal.
// Latency: outputs update SYNC_STAGES clocks after square_in is first sampled at a new level.
// Backpressure: none; free-running, one-cycle code_valid pulse per measured edge.
// Ports:
//   clk, reset_n       - clock and asynchronous active-low reset
//   square_in          - square wave input, asynchronous to clk
//   freq_code          - last measured code (clocks between toggles minus 1)
//   code_valid         - one-cycle pulse when freq_code is refreshed by a measurement
//   locked             - high while the last LOCK_COUNT measurements agree
//   no_signal          - high when no toggle has been seen since reset or last timeout
module square_wave_detector #(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             square_in,
    output logic [WIDTH-1:0] freq_code,
    output logic             code_valid,
    output logic             locked,
    output logic             no_signal
);

    localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_det;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic             meas_q, meas_d;     // a measurement has been taken since leaving ARM
    logic [WIDTH-1:0] freq_q, freq_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             nosig_q, nosig_d;

    // Synchronizer plus history flop; both polarities of transition count as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], square_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] ^ hist_q;

    // Interval counter: restarts on every edge, so at an edge it holds interval-1.
    always_comb begin
        cnt_d = cnt_q;
        if (edge_det) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        meas_d    = meas_q;
        freq_d    = freq_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        nosig_d   = nosig_q;
        match_inc = match_q + MW'(1);

        case (state_q)
            ARM: begin
                // First edge only opens the timing window.
                if (edge_det) begin
                    state_d = TRACK;
                    match_d = '0;
                    meas_d  = 1'b0;
                    nosig_d = 1'b0;
                end
            end
            TRACK: begin
                if (edge_det) begin
                    freq_d  = cnt_q;
                    valid_d = 1'b1;
                    meas_d  = 1'b1;
                    // freq_q is only a real measurement once meas_q is set.
                    if (meas_q && (cnt_q == freq_q)) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_LAST) begin
                            state_d  = LOCK;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ARM;
                    nosig_d  = 1'b1;
                    locked_d = 1'b0;
                    freq_d   = '0;
                    match_d  = '0;
                end
            end
            LOCK: begin
                if (edge_det) begin
                    valid_d = 1'b1;
                    if (cnt_q != freq_q) begin
                        freq_d   = cnt_q;
                        locked_d = 1'b0;
                        match_d  = '0;
                        state_d  = TRACK;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = ARM;
                    nosig_d  = 1'b1;
                    locked_d = 1'b0;
                    freq_d   = '0;
                    match_d  = '0;
                end
            end
            default: begin
                state_d = ARM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            state_q  <= ARM;
            match_q  <= '0;
            meas_q   <= 1'b0;
            freq_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            nosig_q  <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            match_q  <= match_d;
            meas_q   <= meas_d;
            freq_q   <= freq_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            nosig_q  <= nosig_d;
        end
    end

    assign freq_code  = freq_q;
    assign code_valid = valid_q;
    assign locked     = locked_q;
    assign no_signal  = nosig_q;

endmodule

// File: tb/tb_square_wave_detector.sv
// Purpose: scoreboard bench for square_wave_detector; toggles push expected pulses,
//          a monitor pops and compares on every code_valid.
module tb_square_wave_detector;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       square_in;
    logic [7:0] freq_code;
    logic       code_valid;
    logic       locked;
    logic       no_signal;

    typedef struct {
        int code;
        bit lk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    square_wave_detector #(
        .WIDTH      (8),
        .LOCK_COUNT (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .square_in (square_in),
        .freq_code (freq_code),
        .code_valid(code_valid),
        .locked    (locked),
        .no_signal (no_signal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Wait w clocks, then toggle; if a measurement is expected, queue its result.
    task automatic tog(input int w, input bit p, input int code, input bit lk);
        exp_t e;
        repeat (w) @(negedge clk);
        square_in = ~square_in;
        if (p) begin
            e.code = code;
            e.lk   = lk;
            q.push_back(e);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && code_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_code_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_freq_code", int'(freq_code), e.code);
                    chk("pulse_locked", int'(locked), int'(e.lk));
                    chk("pulse_no_signal", int'(no_signal), 0);
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        square_in = 1'b0;
        fork
            monitor();
        join_none

        // Reset and static input
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_freq_code", int'(freq_code), 0);
        chk("rst_code_valid", int'(code_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_no_signal", int'(no_signal), 1);
        repeat (20) @(negedge clk);
        chk("static_no_signal", int'(no_signal), 1);

        // Steady tone, toggle every 10 clocks
        tog(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("first_edge_no_signal", int'(no_signal), 0);
        chk("first_edge_locked", int'(locked), 0);
        tog(7, 1, 9, 0);
        tog(10, 1, 9, 0);
        tog(10, 1, 9, 1);
        tog(10, 1, 9, 1);

        // Retune to 21 clocks
        tog(21, 1, 20, 0);
        tog(21, 1, 20, 0);
        tog(21, 1, 20, 1);
        tog(21, 1, 20, 1);

        // Back to 10, then loss of signal
        tog(10, 1, 9, 0);
        tog(10, 1, 9, 0);
        tog(10, 1, 9, 1);
        repeat (258) @(negedge clk);
        chk("pre_timeout_no_signal", int'(no_signal), 0);
        chk("pre_timeout_locked", int'(locked), 1);
        @(negedge clk);
        chk("timeout_no_signal", int'(no_signal), 1);
        chk("timeout_locked", int'(locked), 0);
        chk("timeout_freq_code", int'(freq_code), 0);

        // Resume from ARM; 256-clock interval meets saturation, edge wins
        tog(5, 0, 0, 0);
        tog(256, 1, 255, 0);
        tog(256, 1, 255, 0);
        tog(256, 1, 255, 1);

        // 257-clock interval times out every time
        tog(257, 0, 0, 0);
        tog(257, 0, 0, 0);
        tog(257, 0, 0, 0);
        repeat (259) @(negedge clk);
        chk("slow_no_signal", int'(no_signal), 1);
        chk("slow_freq_code", int'(freq_code), 0);
        chk("slow_locked", int'(locked), 0);

        // Toggle every clock
        tog(3, 0, 0, 0);
        tog(1, 1, 0, 0);
        tog(1, 1, 0, 0);
        tog(1, 1, 0, 1);
        tog(1, 1, 0, 1);
        repeat (6) @(negedge clk);
        chk("fast_locked_hold", int'(locked), 1);

        // Asynchronous reset while locked
        @(posedge clk);
        #2;
        reset_n   = 1'b0;
        square_in = 1'b0;
        #1;
        chk("async_rst_freq_code", int'(freq_code), 0);
        chk("async_rst_code_valid", int'(code_valid), 0);
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_no_signal", int'(no_signal), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Re-lock from ARM
        tog(3, 0, 0, 0);
        tog(10, 1, 9, 0);
        tog(10, 1, 9, 0);
        tog(10, 1, 9, 1);
        repeat (5) @(negedge clk);
        chk("relock_locked", int'(locked), 1);
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/square_wave_detector.md
# square_wave_detector

Measures the half-period of an incoming square wave and recovers the frequency control code that would produce it, the receive-side counterpart of the square-wave tone generator. It sits on the audio input path: a 1-bit square wave goes in, and an 8-bit code comes out. The code uses the same convention the generator takes as `frequency_control`: a level toggle every `code+1` clocks. The block also reports per-measurement valid pulses, a lock indication once the pitch is stable, and loss of signal.

## Interface
- `WIDTH`, 8: width of the recovered code and of the interval counter.
- `LOCK_COUNT`, 3: number of consecutive identical measurements required to assert `locked` (≥2).
- `SYNC_STAGES`, 2: flops in the input synchronizer (≥2).

- `clk` input 1: system clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `square_in` input 1: square wave to measure; asynchronous to `clk`.
- `freq_code` output `WIDTH`: last measured code (clocks between toggles minus 1).
- `code_valid` output 1: one-cycle pulse when `freq_code` is updated with a new measurement.
- `locked` output 1: high while the last `LOCK_COUNT` measurements are identical.
- `no_signal` output 1: high when no toggle has been seen since reset or since the last timeout.

## Operation
- **Synchronizer.** `square_in` passes through `SYNC_STAGES` flops, then one history flop; all reset to 0. `edge` is the synchronizer output XOR history, so both rising and falling transitions count.
- **Interval counter.** `cnt` is `WIDTH` bits and resets to 0.
  - An edge cycle loads `cnt` with 0.
  - Otherwise `cnt` increments, saturating at `2^WIDTH-1`.
  - At an edge, `cnt` equals the toggle interval minus 1.
- **FSM.** States are ARM, TRACK and LOCK; the reset state is ARM.
  - ARM
    - `no_signal`=1.
    - The first edge only starts timing: no `code_valid`. Go to TRACK, `cnt`←0, `match`←0, `no_signal`←0.
  - TRACK
    - On an edge: `freq_code`←`cnt`, `code_valid`=1.
    - If `cnt`==`freq_code` (the previous value) and at least one measurement has been taken since ARM, then `match`++. Otherwise `match`←0.
    - When `match` reaches `LOCK_COUNT-1`, go to LOCK and set `locked`←1 in the same update.
  - LOCK
    - Edge with `cnt`==`freq_code`: stay in LOCK, `code_valid`=1.
    - Edge with `cnt`≠`freq_code`: `freq_code`←`cnt`, `code_valid`=1, `locked`←0, `match`←0, go to TRACK.
- **Timeout.** In TRACK or LOCK, a cycle with `cnt`==`2^WIDTH-1` and no edge causes:
  - go to ARM;
  - `no_signal`←1, `locked`←0, `freq_code`←0, `match`←0;
  - no `code_valid`.
- **Simultaneous edge and saturation.** The edge wins: it is a valid measurement with code `2^WIDTH-1` and no timeout occurs.
- **Width rules.**
  - `match` is sized to hold `LOCK_COUNT-1`.
  - The maximum measurable half-period is `2^WIDTH` clocks.
  - A half-period of 1 clock gives code 0.

## Timing
- **Reset values.** `freq_code`=0, `code_valid`=0, `locked`=0, `no_signal`=1, FSM=ARM, `cnt`=0.
- **Reset behaviour.** Assertion takes effect immediately, asynchronously and mid-operation included. Deassertion is not synchronized inside this block: it must be released synchronously to `clk` upstream.
- **Latency.** With `square_in` first sampled at its new level on clock edge k, `edge` is high between edges k+`SYNC_STAGES`-1 and k+`SYNC_STAGES`. All outputs update at edge k+`SYNC_STAGES`.
- **Registered outputs.** All outputs come straight from flops; no combinational path from `square_in`.
- **Pulse width.** `code_valid` is high exactly one cycle per measured edge. `freq_code` is stable between pulses.
- **Lock timing.** `locked` rises in the same cycle as the `LOCK_COUNT`-th identical `code_valid` pulse. It falls in the same cycle as the first mismatching pulse or the timeout.
- **Timeout timing.** `no_signal` rises `2^WIDTH` clocks after the last detected edge. It falls together with the first edge detected after ARM.

## Test plan
- **Reset.** Hold `reset_n`=0, then release → `freq_code`=0, `code_valid`=0, `locked`=0, `no_signal`=1; no `code_valid` pulses with `square_in` static.
- **Steady tone.** Toggle `square_in` every 10 clocks → `no_signal` falls at the first detected edge with no pulse. `code_valid` then pulses every 10 clocks with `freq_code`=9. `locked` rises on the 3rd pulse.
- **Retune.** While locked, switch to toggling every 21 clocks → the first differing pulse drops `locked` in the same cycle. `freq_code` settles at 20, and `locked` rises again after 3 consecutive pulses with code 20.
- **Loss of signal.** While locked at code 9, freeze `square_in` → exactly 256 clocks after the last edge: `no_signal`=1, `locked`=0, `freq_code`=0. Resuming toggles restarts from ARM.
- **Boundaries.**
  - Toggle every 256 clocks → edge coincides with counter saturation; `freq_code`=255, no timeout.
  - Toggle every 257 clocks → timeout each interval; `code_valid` never pulses.
  - Toggle every clock → `freq_code`=0 and `locked` asserts.
- **Reset mid-lock.** Assert `reset_n`=0 asynchronously between clock edges while locked → all outputs return to reset values before the next rising edge. After release the block re-locks from ARM.
